rpu_minsum_ctrl: RTL and testbench
==================================

RPU_MINSUM_CTRL -- requirements
Module: rpu_minsum_ctrl

Interface
REQ-001 Parameter W, default 6, message width in two's complement; magnitude width is W-1.
REQ-002 Parameter MAX_DEG, default 32, maximum row degree.
REQ-003 Parameter IDX_W, default 5, index width; the design SHALL hold 2^IDX_W >= MAX_DEG.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  row-start request; sampled only in IDLE.
REQ-007 deg  in  IDX_W+1  row degree, sampled with start.
REQ-008 in_valid  in  1  message beat valid.
REQ-009 in_data  in  W  message, two's complement.
REQ-010 in_ready  out  1  block accepts a beat; a beat transfers when in_valid and in_ready are both 1.
REQ-011 out_valid  out  1  row result valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 min1, min2  out  W-1 each  smallest and second-smallest magnitudes.
REQ-014 min1_idx  out  IDX_W  beat index (0-based) of min1.
REQ-015 sign_prod  out  1  XOR of all message sign bits in the row.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 err  out  1  one-cycle pulse on an illegal degree.

Function
REQ-018 FSM states: IDLE, ACCUM, DONE; in_ready SHALL be 1 only in ACCUM, and out_valid SHALL be 1 only in DONE.
REQ-019 In IDLE, start=1 with deg in 1..MAX_DEG SHALL latch deg, clear the beat counter, set min1 and min2 to all-ones, set min1_idx=0 and sign_prod=0, and move to ACCUM next cycle.
REQ-020 In IDLE, start=1 with deg=0 or deg>MAX_DEG SHALL pulse err for exactly one cycle and remain in IDLE with results unchanged.
REQ-021 start SHALL be ignored in ACCUM and DONE.
REQ-022 Per accepted beat, magnitude m is computed as follows: non-negative input gives in_data[W-2:0]; negative input gives its two's-complement negation; the most negative input (sign=1, low bits all zero) SHALL saturate to all-ones (2^(W-1)-1).
REQ-023 If m < min1: min2 <= min1, min1 <= m, min1_idx <= counter.
REQ-024 Else if m < min2: min2 <= m. Ties with min1 therefore land in min2, and min1_idx keeps the earliest index.
REQ-025 sign_prod SHALL toggle by in_data[W-1] on every accepted beat, and the counter SHALL increment.
REQ-026 The beat with counter == deg-1 SHALL be the last beat; the state SHALL move to DONE on the following edge, so out_valid rises exactly one cycle after the last transfer.
REQ-027 In DONE, min1, min2, min1_idx and sign_prod SHALL be stable; on out_ready=1 the state SHALL return to IDLE next cycle.
REQ-028 Results SHALL keep their last values through IDLE until the next legal start.
REQ-029 With deg=1, min2 SHALL remain all-ones.
REQ-030 in_valid in IDLE or DONE SHALL be ignored, and no beat SHALL be consumed.
REQ-031 Minimum row turnaround is deg+2 cycles: start, deg beats, then DONE with an immediate out_ready.

Reset
REQ-032 While rst_n=0 at a clock edge, the state SHALL become IDLE, and in_ready, out_valid, busy, err, min1, min2, min1_idx, sign_prod and the counter SHALL all be 0.
REQ-033 Reset asserted mid-row SHALL discard the partial row; the first legal start after release SHALL be processed from a clean state.

Verification
REQ-034 Case 1 (W=6): deg=4, beats 0x05, 0x3D, 0x07, 0x3D -> min1=3, min1_idx=1, min2=3, sign_prod=0; out_valid is 1 on the cycle after beat 4.
REQ-035 Case 2: deg=2, beats 0x20, 0x1F -> min1=31, min1_idx=0, min2=31, sign_prod=1 (saturation).
REQ-036 Case 3: deg=1, beat 0x3F -> min1=1, min2=31, min1_idx=0, sign_prod=1.
REQ-037 Case 4: hold out_ready=0 for 5 cycles in DONE while pulsing start and in_valid -> outputs stay constant and in_ready=0; one cycle after out_ready=1, busy=0.
REQ-038 Case 5: rst_n=0 for one cycle after 2 of 4 beats -> all outputs are 0 next cycle; a new deg=2 row with beats 0x02, 0x01 -> min1=1, min1_idx=1, min2=2.
REQ-039 Case 6: start with deg=0, then deg=33 -> err is high for one cycle each, busy stays 0, and prior results are unchanged.

Source files
------------

// File: rtl/rpu_minsum_ctrl.sv
// Min-sum check-node row controller: streams one row of signed messages and
// reports the two smallest magnitudes, the index of the smallest and the sign product.
module rpu_minsum_ctrl #(
    parameter int unsigned W       = 6,
    parameter int unsigned MAX_DEG = 32,
    parameter int unsigned IDX_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IDX_W:0]     deg,
    input  logic               in_valid,
    input  logic [W-1:0]       in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-2:0]       min1,
    output logic [W-2:0]       min2,
    output logic [IDX_W-1:0]   min1_idx,
    output logic               sign_prod,
    output logic               busy,
    output logic               err
);

    localparam int unsigned MW    = W - 1;
    localparam int unsigned DEG_W = IDX_W + 1;

    // Elaboration guard: every beat index of a maximum-degree row must fit in min1_idx.
    if ((64'd1 << IDX_W) < 64'(MAX_DEG)) begin : g_idx_chk
        $error("rpu_minsum_ctrl: 2**IDX_W must be >= MAX_DEG");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [DEG_W-1:0] deg_q;
    logic [DEG_W-1:0] cnt;

    logic             deg_ok_c;
    logic             accept_c;
    logic             beat_c;
    logic             last_c;
    logic [W-1:0]     neg_c;
    logic [MW-1:0]    mag_c;

    // Row-start qualification and beat transfer decode.
    always_comb begin
        deg_ok_c = (deg != '0) && (deg <= DEG_W'(MAX_DEG));
        accept_c = (state == S_IDLE) && start && deg_ok_c;
        beat_c   = (state == S_ACCUM) && in_valid;
        last_c   = beat_c && (cnt == (deg_q - DEG_W'(1)));
    end

    // Magnitude of the incoming message; the most negative code saturates.
    always_comb begin
        neg_c = (~in_data) + W'(1);
        mag_c = in_data[MW-1:0];
        if (in_data[W-1]) begin
            if (in_data[MW-1:0] == '0) begin
                mag_c = '1;
            end else begin
                mag_c = neg_c[MW-1:0];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept_c)  next_state = S_ACCUM;
            S_ACCUM: if (last_c)    next_state = S_DONE;
            S_DONE:  if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register and registered handshake/status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == S_ACCUM);
            out_valid <= (next_state == S_DONE);
            busy      <= (next_state != S_IDLE);
            err       <= (state == S_IDLE) && start && !deg_ok_c;
        end
    end

    // Row datapath: results hold outside ACCUM until the next legal start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deg_q     <= '0;
            cnt       <= '0;
            min1      <= '0;
            min2      <= '0;
            min1_idx  <= '0;
            sign_prod <= 1'b0;
        end else if (accept_c) begin
            deg_q     <= deg;
            cnt       <= '0;
            min1      <= '1;
            min2      <= '1;
            min1_idx  <= '0;
            sign_prod <= 1'b0;
        end else if (beat_c) begin
            cnt       <= cnt + DEG_W'(1);
            sign_prod <= sign_prod ^ in_data[W-1];
            if (mag_c < min1) begin
                min2     <= min1;
                min1     <= mag_c;
                min1_idx <= cnt[IDX_W-1:0];
            end else if (mag_c < min2) begin
                min2 <= mag_c;
            end
        end
    end

endmodule

// File: tb/tb_rpu_minsum_ctrl.sv
// Scoreboard bench for rpu_minsum_ctrl: directed rows push expected results,
// a monitor compares them at each result handshake.
module tb_rpu_minsum_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] deg;
    logic       in_valid;
    logic [5:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] min1;
    logic [4:0] min2;
    logic [4:0] min1_idx;
    logic       sign_prod;
    logic       busy;
    logic       err;

    typedef struct packed {
        logic [4:0] m1;
        logic [4:0] m2;
        logic [4:0] idx;
        logic       sgn;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    rpu_minsum_ctrl #(.W(6), .MAX_DEG(32), .IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .deg(deg),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .min1(min1), .min2(min2), .min1_idx(min1_idx), .sign_prod(sign_prod),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: compare the result presented at each out_valid/out_ready handshake.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("sb_min1", int'(min1), int'(e.m1));
                chk("sb_min2", int'(min2), int'(e.m2));
                chk("sb_min1_idx", int'(min1_idx), int'(e.idx));
                chk("sb_sign_prod", int'(sign_prod), int'(e.sgn));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_row(input logic [5:0] d);
        start = 1'b1;
        deg   = d;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [5:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push(input int m1, input int m2, input int idx, input int sgn);
        res_t e;
        e.m1  = 5'(m1);
        e.m2  = 5'(m2);
        e.idx = 5'(idx);
        e.sgn = 1'(sgn);
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_min1"}, int'(min1), 0);
        chk({tag, "_min2"}, int'(min2), 0);
        chk({tag, "_min1_idx"}, int'(min1_idx), 0);
        chk({tag, "_sign_prod"}, int'(sign_prod), 0);
    endtask

    initial begin
        logic [4:0] h_m1, h_m2, h_idx;
        logic       h_sgn;
        rst_n     = 1'b0;
        start     = 1'b0;
        deg       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Case 1: tie with min1 lands in min2, earliest index kept.
        push(3, 3, 1, 0);
        start_row(6'd4);
        chk("c1_busy", int'(busy), 1);
        chk("c1_in_ready", int'(in_ready), 1);
        chk("c1_min1_init", int'(min1), 31);
        chk("c1_min2_init", int'(min2), 31);
        beat(6'h05);
        beat(6'h3D);
        beat(6'h07);
        chk("c1_no_early_valid", int'(out_valid), 0);
        beat(6'h3D);
        chk("c1_out_valid", int'(out_valid), 1);
        chk("c1_in_ready_done", int'(in_ready), 0);
        tick();
        chk("c1_busy_after", int'(busy), 0);

        // Case 2: most negative input saturates.
        push(31, 31, 0, 1);
        start_row(6'd2);
        beat(6'h20);
        beat(6'h1F);
        chk("c2_out_valid", int'(out_valid), 1);
        tick();

        // Case 3: single-beat row keeps min2 at all-ones.
        push(1, 31, 0, 1);
        start_row(6'd1);
        beat(6'h3F);
        chk("c3_out_valid", int'(out_valid), 1);
        tick();

        // Case 4: stall in DONE while start/in_valid are pulsed.
        push(4, 6, 0, 1);
        out_ready = 1'b0;
        start_row(6'd2);
        beat(6'h04);
        beat(6'h3A);
        for (int i = 0; i < 5; i++) begin
            start    = 1'b1;
            deg      = 6'd3;
            in_valid = 1'b1;
            in_data  = 6'h01;
            tick();
            chk("c4_out_valid_hold", int'(out_valid), 1);
            chk("c4_in_ready_low", int'(in_ready), 0);
            chk("c4_min1_hold", int'(min1), 4);
            chk("c4_min2_hold", int'(min2), 6);
            chk("c4_idx_hold", int'(min1_idx), 0);
            chk("c4_sign_hold", int'(sign_prod), 1);
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("c4_busy_after", int'(busy), 0);
        chk("c4_out_valid_after", int'(out_valid), 0);
        chk("c4_results_kept_idle", int'(min2), 6);

        // Case 6: illegal degrees pulse err and leave results alone.
        h_m1 = min1; h_m2 = min2; h_idx = min1_idx; h_sgn = sign_prod;
        start_row(6'd0);
        chk("c6_err_deg0", int'(err), 1);
        chk("c6_busy_deg0", int'(busy), 0);
        tick();
        chk("c6_err_deg0_clear", int'(err), 0);
        start_row(6'd33);
        chk("c6_err_deg33", int'(err), 1);
        chk("c6_busy_deg33", int'(busy), 0);
        tick();
        chk("c6_err_deg33_clear", int'(err), 0);
        chk("c6_busy_stays", int'(busy), 0);
        chk("c6_min1_kept", int'(min1), 4);
        chk("c6_min2_kept", int'(min2), 6);
        chk("c6_idx_kept", int'(min1_idx), int'(h_idx));
        chk("c6_sign_kept", int'(sign_prod), 1);
        if (h_m1 != 5'd4 || h_m2 != 5'd6 || h_sgn != 1'b1) chk("c6_prior_snapshot", 0, 1);

        // Case 5: reset mid-row discards the partial row.
        start_row(6'd4);
        beat(6'h02);
        beat(6'h01);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_all_zero("c5_reset");
        push(1, 2, 1, 0);
        start_row(6'd2);
        beat(6'h02);
        beat(6'h01);
        chk("c5_out_valid", int'(out_valid), 1);
        tick();
        tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
